// File: rtl/riscv_alu.sv
// RV32I integer ALU: a combinational result selected by ALUct1, captured in one
// output register. zero is decoded from that register so it lines up with ALUout.
module riscv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ALUct1,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUout,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SLTU  = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_PASSB = 4'b1010,
        OP_NOR   = 4'b1100
    } alu_op_e;

    alu_op_e          op;
    logic [SHW-1:0]   shamt;
    logic             shift_fill;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] shift_out_rev;
    logic [WIDTH-1:0] shift_stage [0:SHW];
    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;

    assign op    = alu_op_e'(ALUct1);
    assign shamt = B[SHW-1:0];

    // One right-shifting barrel serves all three shifts: SLL runs on the
    // bit-reversed operand and the result is reversed back.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign a_rev[gi]         = A[WIDTH-1-gi];
            assign shift_out_rev[gi] = shift_out[WIDTH-1-gi];
        end
    endgenerate

    assign shift_in       = (op == OP_SLL) ? a_rev : A;
    assign shift_fill     = (op == OP_SRA) & A[WIDTH-1];
    assign shift_stage[0] = shift_in;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
            localparam int STEP = 1 << gi;
            assign shift_stage[gi+1] = shamt[gi]
                ? {{STEP{shift_fill}}, shift_stage[gi][WIDTH-1:STEP]}
                : shift_stage[gi];
        end
    endgenerate

    assign shift_out = shift_stage[SHW];

    always_comb begin
        alu_out_d = '0;
        case (op)
            OP_AND:   alu_out_d = A & B;
            OP_OR:    alu_out_d = A | B;
            OP_ADD:   alu_out_d = A + B;
            OP_XOR:   alu_out_d = A ^ B;
            OP_SLL:   alu_out_d = shift_out_rev;
            OP_SRL:   alu_out_d = shift_out;
            OP_SUB:   alu_out_d = A - B;
            OP_SLT:   alu_out_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  alu_out_d = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SRA:   alu_out_d = shift_out;
            OP_PASSB: alu_out_d = B;
            OP_NOR:   alu_out_d = ~(A | B);
            default:  alu_out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign ALUout = alu_out_q;
    assign zero   = (alu_out_q == '0);

endmodule

// File: tb/tb_riscv_alu.sv
// Bench for riscv_alu: directed vector table, async-reset sequences, and random
// operations checked against an arithmetic reference model.
module tb_riscv_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  ALUct1;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUout;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    riscv_alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .ALUct1 (ALUct1),
        .A      (A),
        .B      (B),
        .ALUout (ALUout),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        int              sh = int'(b[4:0]);
        longint unsigned pow = 64'd1 << sh;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((ua + ub) % 64'h1_0000_0000);
            4'd3:  return a ^ b;
            4'd4:  return 32'((ua * pow) % 64'h1_0000_0000);
            4'd5:  return 32'(ua / pow);
            4'd6:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return (ua < ub) ? 32'd1 : 32'd0;
            // floor division of the sign-extended value
            4'd9:  begin
                longint q = (sa >= 0) ? sa / longint'(pow)
                                      : -((-sa + longint'(pow) - 1) / longint'(pow));
                return 32'(q);
            end
            4'd10: return b;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] exp);
        check({name, ".ALUout"}, ALUout, exp);
        check({name, ".zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        $display("%-12s op=%b A=%08h B=%08h -> ALUout=%08h zero=%0b (exp %08h)",
                 name, ALUct1, A, B, ALUout, zero, exp);
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUct1 = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"and",      4'b0000, 32'h11,       32'h1,        32'h1};
        vecs[1]  = '{"sub",      4'b0110, 32'h11,       32'h1,        32'h10};
        vecs[2]  = '{"sub_eq",   4'b0110, 32'h1234,     32'h1234,     32'h0};
        vecs[3]  = '{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0};
        vecs[4]  = '{"slt",      4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1};
        vecs[5]  = '{"sltu",     4'b1000, 32'hFFFFFFFF, 32'h1,        32'h0};
        vecs[6]  = '{"sra",      4'b1001, 32'h80000000, 32'h24,       32'hF8000000};
        vecs[7]  = '{"srl",      4'b0101, 32'h80000000, 32'h24,       32'h08000000};
        vecs[8]  = '{"sll",      4'b0100, 32'h1,        32'h24,       32'h10};
        vecs[9]  = '{"passb",    4'b1010, 32'h12345678, 32'hABCD0000, 32'hABCD0000};
        vecs[10] = '{"nor",      4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF};
        vecs[11] = '{"op1111",   4'b1111, 32'hDEADBEEF, 32'h5,        32'h0};
        vecs[12] = '{"op1011",   4'b1011, 32'h5,        32'h3,        32'h0};
        vecs[13] = '{"sra_sh0",  4'b1001, 32'h80000001, 32'h20,       32'h80000001};
        vecs[14] = '{"or",       4'b0001, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0};
        vecs[15] = '{"xor",      4'b0011, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00};

        ALUct1 = 4'b0000;
        A      = 32'h11;
        B      = 32'h1;
        rst    = 1'b1;
        #1 rst = 1'b0;

        // Reset held across several edges keeps the output cleared.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_out("rst_hold", 32'h0);
        end

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check_out(vecs[i].name, vecs[i].exp);
        end

        // Inputs changing between edges must not reach ALUout.
        apply(4'b0010, 32'd100, 32'd23);
        check_out("add", 32'd123);
        ALUct1 = 4'b0110;
        A      = 32'd7;
        B      = 32'd7;
        #2;
        check_out("mid_change", 32'd123);
        @(posedge clk);
        #1;
        check_out("next_edge", 32'd0);

        // Asynchronous reset mid-cycle, release before the next edge.
        apply(4'b0001, 32'hA5A50000, 32'h00005A5A);
        check_out("pre_rst", 32'hA5A55A5A);
        #2 rst = 1'b0;
        #1 check_out("async_rst", 32'h0);
        #1 rst = 1'b1;
        #1 check_out("rst_release", 32'h0);
        @(posedge clk);
        #1;
        check_out("post_rst", 32'hA5A55A5A);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: a = {a[31], 31'h0} | 32'($urandom_range(0, 3));
                default: ;
            endcase
            apply(op, a, b);
            check_out("random", ref_alu(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
